// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised raster timing generator. A pair of pixel/line counters walks
// the full frame (blanking first, active area last). One registered stage
// later it issues coordinate requests to a pixel source with a fixed read
// latency of PIX_LAT cycles. The sync/blank/pulse timing for the same
// position travels down a PIX_LAT-deep delay line, so the returned RGB and the
// sync outputs leave the final output register together.
//
// Ports:
//   pixel_clk    pixel clock, all logic on its rising edge
//   pixel_rst    synchronous active-high reset (no pipeline drain)
//   en           run request, honoured only at frame boundaries
//   req_valid    coordinate request valid (active pixel)
//   req_x/req_y  requested column/line, 0 when req_valid=0
//   rgb_in       pixel data, valid PIX_LAT cycles after its request
//   hs/vs        horizontal/vertical sync, polarity set by HS_POL/VS_POL
//   blank        1 outside the active area
//   rgb_out      pixel data aligned with hs/vs/blank, 0 while blanked
//   line_start   one-cycle pulse on the first cycle of each line
//   frame_start  one-cycle pulse on the first cycle of each frame
//   running      1 while the counters are running
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int HDISP   = 800,
    parameter int VDISP   = 480,
    parameter int HFP     = 40,
    parameter int HPULSE  = 48,
    parameter int HBP     = 40,
    parameter int VFP     = 12,
    parameter int VPULSE  = 3,
    parameter int VBP     = 40,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int PIX_LAT = 0,
    parameter int RGB_W   = 24
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst,
    input  logic                       en,
    output logic                       req_valid,
    output logic [$clog2(HDISP)-1:0]   req_x,
    output logic [$clog2(VDISP)-1:0]   req_y,
    input  logic [RGB_W-1:0]           rgb_in,
    output logic                       hs,
    output logic                       vs,
    output logic                       blank,
    output logic [RGB_W-1:0]           rgb_out,
    output logic                       line_start,
    output logic                       frame_start,
    output logic                       running
);

    localparam int HBLK   = HFP + HPULSE + HBP;
    localparam int HTOTAL = HBLK + HDISP;
    localparam int VBLK   = VFP + VPULSE + VBP;
    localparam int VTOTAL = VBLK + VDISP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int XW     = $clog2(HDISP);
    localparam int YW     = $clog2(VDISP);

    typedef enum logic {IDLE, RUN} state_t;

    // Timing attributes of one raster position as it moves down the pipe.
    typedef struct packed {
        logic valid;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } tim_t;

    localparam tim_t TIM_IDLE = '{valid: 1'b0, hs: ~HS_POL, vs: ~VS_POL,
                                  ls: 1'b0, fs: 1'b0};

    state_t         state;
    logic [HW-1:0]  hcnt;
    logic [VW-1:0]  vcnt;
    tim_t           cur;
    // pipe[0] is the request stage; pipe[PIX_LAT] feeds the output register.
    tim_t           pipe [0:PIX_LAT];

    logic h_last;
    logic v_last;
    assign h_last = (hcnt == HW'(HTOTAL - 1));
    assign v_last = (vcnt == VW'(VTOTAL - 1));

    // ------------------------------------------------------------------
    // Stage 0: run/idle control and raster counters. Leaving RUN is only
    // possible on the last pixel of a frame, so frames are never cut short.
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            state   <= IDLE;
            running <= 1'b0;
            hcnt    <= '0;
            vcnt    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            case (state)
                IDLE: begin
                    if (en) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (h_last) begin
                        hcnt <= '0;
                        if (v_last) begin
                            vcnt <= '0;
                            if (!en) begin
                                state   <= IDLE;
                                running <= 1'b0;
                            end
                        end else begin
                            vcnt <= vcnt + 1'b1;
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Decode of the current counter position; IDLE feeds inactive values.
    always_comb begin
        cur = TIM_IDLE;
        if (state == RUN) begin
            cur.valid = (hcnt >= HW'(HBLK)) && (vcnt >= VW'(VBLK));
            cur.hs    = ((hcnt >= HW'(HFP)) && (hcnt < HW'(HFP + HPULSE)))
                        ? HS_POL : ~HS_POL;
            cur.vs    = ((vcnt >= VW'(VFP)) && (vcnt < VW'(VFP + VPULSE)))
                        ? VS_POL : ~VS_POL;
            cur.ls    = (hcnt == '0);
            cur.fs    = (hcnt == '0) && (vcnt == '0);
        end
    end

    // ------------------------------------------------------------------
    // Request stage plus the PIX_LAT-deep timing delay line.
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            // NOTE: the delay line is reset element by element on purpose;
            // stale sync/blank values must never reach the outputs after a
            // mid-frame reset.
            for (int i = 0; i <= PIX_LAT; i++) begin
                pipe[i] <= TIM_IDLE;
            end
            req_x <= '0;
            req_y <= '0;
        end else begin
            pipe[0] <= cur;
            req_x   <= cur.valid ? XW'(hcnt - HW'(HBLK)) : '0;
            req_y   <= cur.valid ? YW'(vcnt - VW'(VBLK)) : '0;
            for (int i = 1; i <= PIX_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign req_valid = pipe[0].valid;

    // ------------------------------------------------------------------
    // Output register: the last delay stage and rgb_in now refer to the
    // same raster position.
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            blank       <= 1'b1;
            rgb_out     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hs          <= pipe[PIX_LAT].hs;
            vs          <= pipe[PIX_LAT].vs;
            blank       <= ~pipe[PIX_LAT].valid;
            rgb_out     <= pipe[PIX_LAT].valid ? rgb_in : '0;
            line_start  <= pipe[PIX_LAT].ls;
            frame_start <= pipe[PIX_LAT].fs;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Small asymmetric raster (11 x 7 positions, mixed sync polarities,
// PIX_LAT=3) so whole frames, stop/start at frame boundaries and resets
// fit in a short run. A frame-position model pushes the expected request
// and output for every counted position into two queues; a monitor pops
// and compares on every cycle, expecting idle values when nothing is due.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HDISP   = 5;
    localparam int VDISP   = 3;
    localparam int HFP     = 2;
    localparam int HPULSE  = 3;
    localparam int HBP     = 1;
    localparam int VFP     = 1;
    localparam int VPULSE  = 2;
    localparam int VBP     = 1;
    localparam bit HS_POL  = 1'b0;
    localparam bit VS_POL  = 1'b1;
    localparam int PIX_LAT = 3;
    localparam int RGB_W   = 16;

    localparam int HBLK   = HFP + HPULSE + HBP;
    localparam int HTOTAL = HBLK + HDISP;
    localparam int VBLK   = VFP + VPULSE + VBP;
    localparam int VTOTAL = VBLK + VDISP;
    localparam int FRAME  = HTOTAL * VTOTAL;
    localparam int XW     = $clog2(HDISP);
    localparam int YW     = $clog2(VDISP);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic              req_valid;
    logic [XW-1:0]     req_x;
    logic [YW-1:0]     req_y;
    logic [RGB_W-1:0]  rgb_in;
    logic              hs, vs, blank, line_start, frame_start, running;
    logic [RGB_W-1:0]  rgb_out;

    vga_timing_gen #(
        .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(HS_POL),
        .VS_POL(VS_POL), .PIX_LAT(PIX_LAT), .RGB_W(RGB_W)
    ) dut (
        .pixel_clk(clk), .pixel_rst(rst), .en(en),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .rgb_in(rgb_in), .hs(hs), .vs(vs), .blank(blank),
        .rgb_out(rgb_out), .line_start(line_start),
        .frame_start(frame_start), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int h;
        int v;
    } rec_t;

    rec_t req_q[$];
    rec_t out_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   m_run = 1'b0;
    int   m_pos = 0;
    bit   chk   = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit is_active(input int h, input int v);
        return (h >= HBLK) && (v >= VBLK);
    endfunction

    // Pixel source: returns {y,x} PIX_LAT cycles after a valid request,
    // random junk for idle request slots.
    logic [RGB_W-1:0] s1, s2;
    initial forever begin
        @(posedge clk);
        s1     <= req_valid ? RGB_W'({req_y, req_x}) : RGB_W'($urandom);
        s2     <= s1;
        rgb_in <= s2;
    end

    // Frame-position model: m_pos is the linear position inside the frame.
    initial forever begin
        rec_t r;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_run = 1'b0;
            m_pos = 0;
            req_q.delete();
            out_q.delete();
            chk = 1'b1;
        end else if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos == FRAME - 1) begin
            m_pos = 0;
            if (!en) m_run = 1'b0;
        end else begin
            m_pos++;
        end
        if (!rst && m_run) begin
            r.h   = m_pos % HTOTAL;
            r.v   = m_pos / HTOTAL;
            r.due = cyc + 1;
            req_q.push_back(r);
            r.due = cyc + PIX_LAT + 2;
            out_q.push_back(r);
        end
    end

    // Monitor: compares every cycle once the first reset has been seen.
    initial forever begin
        rec_t r;
        bit   have;
        bit   act;
        int   e_x, e_y, e_rgb;
        bit   e_hs, e_vs, e_ls, e_fs;
        @(negedge clk);
        if (chk) begin
            check("running", running, m_run);

            have = 1'b0;
            if (req_q.size() > 0 && req_q[0].due == cyc) begin
                r    = req_q.pop_front();
                have = 1'b1;
            end
            act = have && is_active(r.h, r.v);
            e_x = act ? r.h - HBLK : 0;
            e_y = act ? r.v - VBLK : 0;
            check("req_valid", req_valid, act);
            check("req_x", req_x, e_x);
            check("req_y", req_y, e_y);

            have = 1'b0;
            if (out_q.size() > 0 && out_q[0].due == cyc) begin
                r    = out_q.pop_front();
                have = 1'b1;
            end
            act   = have && is_active(r.h, r.v);
            e_hs  = (have && r.h >= HFP && r.h < HFP + HPULSE) ? HS_POL : !HS_POL;
            e_vs  = (have && r.v >= VFP && r.v < VFP + VPULSE) ? VS_POL : !VS_POL;
            e_ls  = have && (r.h == 0);
            e_fs  = have && (r.h == 0) && (r.v == 0);
            e_rgb = act ? (r.v - VBLK) * (1 << XW) + (r.h - HBLK) : 0;
            check("hs", hs, e_hs);
            check("vs", vs, e_vs);
            check("blank", blank, !act);
            check("rgb_out", rgb_out, e_rgb);
            check("line_start", line_start, e_ls);
            check("frame_start", frame_start, e_fs);
        end
    end

    // Stimulus
    initial begin
        bit found;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Run a few frames, then drop en mid-frame and let it drain.
        en = 1'b1;
        repeat (2 * FRAME + 30) @(negedge clk);
        en = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        // Restart, then reset in the middle of an active line.
        en    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            @(negedge clk);
            if (req_valid && req_x == XW'(2)) found = 1'b1;
        end
        check("found_active", found, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (FRAME + 20) @(negedge clk);

        // Random en toggling with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) en = ~en;
            rst = ($urandom_range(0, 599) == 0);
        end
        rst = 1'b0;
        en  = 1'b0;

        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (!running) break;
        end
        check("stop_timeout", running, 1'b0);
        repeat (PIX_LAT + 5) @(negedge clk);
        check("req_q_drained", req_q.size(), 0);
        check("out_q_drained", out_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
